// File: rtl/if_id_skid_stage_if.sv
// Valid/ready stream carrying one fetched instruction (pc + instruction word).
// The master drives valid/pc/inst and the slave drives ready.
interface if_id_skid_stage_if #(
  parameter int PC_W   = 64,
  parameter int INST_W = 32
) ();
  logic              valid;
  logic [PC_W-1:0]   pc;
  logic [INST_W-1:0] inst;
  logic              ready;

  modport master (output valid, pc, inst, input ready);
  modport slave  (input valid, pc, inst, output ready);
endinterface

// File: rtl/if_id_skid_stage.sv
// IF->ID pipeline register with a 2-entry skid buffer, a synchronous flush
// and a saturating counter of cycles in which decode was starved.
module if_id_skid_stage #(
  parameter int                PC_W        = 64,
  parameter int                INST_W      = 32,
  parameter logic [INST_W-1:0] BUBBLE_INST = '0,
  parameter int                CNT_W       = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  if_id_skid_stage_if.slave    up,
  if_id_skid_stage_if.master   dn,
  output logic [1:0]           occupancy,
  output logic [CNT_W-1:0]     bubble_cnt
);

  // Encodings double as the occupancy count.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [PC_W-1:0]   main_pc_q, main_pc_d;
  logic [INST_W-1:0] main_inst_q, main_inst_d;
  logic [PC_W-1:0]   skid_pc_q, skid_pc_d;
  logic [INST_W-1:0] skid_inst_q, skid_inst_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              accept;

  assign accept = up.valid && (state_q != FULL);

  always_comb begin
    state_d     = state_q;
    main_pc_d   = main_pc_q;
    main_inst_d = main_inst_q;
    skid_pc_d   = skid_pc_q;
    skid_inst_d = skid_inst_q;
    cnt_d       = cnt_q;

    // Starvation counter runs independently of flush and saturates.
    if (dn.ready && (state_q == EMPTY) && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end

    if (flush) begin
      state_d     = EMPTY;
      main_pc_d   = '0;
      main_inst_d = BUBBLE_INST;
      skid_pc_d   = '0;
      skid_inst_d = BUBBLE_INST;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            state_d     = ONE;
            main_pc_d   = up.pc;
            main_inst_d = up.inst;
          end
        end
        ONE: begin
          if (accept && dn.ready) begin
            main_pc_d   = up.pc;
            main_inst_d = up.inst;
          end else if (accept) begin
            state_d     = FULL;
            skid_pc_d   = up.pc;
            skid_inst_d = up.inst;
          end else if (dn.ready) begin
            state_d     = EMPTY;
            main_pc_d   = '0;
            main_inst_d = BUBBLE_INST;
          end
        end
        FULL: begin
          if (dn.ready) begin
            state_d     = ONE;
            main_pc_d   = skid_pc_q;
            main_inst_d = skid_inst_q;
          end
        end
        default: begin
          state_d     = EMPTY;
          main_pc_d   = '0;
          main_inst_d = BUBBLE_INST;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= EMPTY;
      main_pc_q   <= '0;
      main_inst_q <= BUBBLE_INST;
      skid_pc_q   <= '0;
      skid_inst_q <= BUBBLE_INST;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      main_pc_q   <= main_pc_d;
      main_inst_q <= main_inst_d;
      skid_pc_q   <= skid_pc_d;
      skid_inst_q <= skid_inst_d;
      cnt_q       <= cnt_d;
    end
  end

  assign up.ready   = (state_q != FULL);
  assign dn.valid   = (state_q != EMPTY);
  assign dn.pc      = main_pc_q;
  assign dn.inst    = main_inst_q;
  assign occupancy  = state_q;
  assign bubble_cnt = cnt_q;

endmodule
